// File: rtl/password_controller.sv
// password_controller: four-digit password gate in front of the game datapath, with failure counting.
// Define PASSWORD_LOCKOUT_EN to compile in the timed lockout after MAX_FAIL consecutive failures.
module password_controller #(
  parameter logic [15:0] PASSWORD    = 16'h5293,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rts,
  input  logic       enter_pulse,
  input  logic       logout_pulse,
  input  logic [3:0] digit_in,
  output logic       access,
  output logic       game_en,
  output logic       fail,
  output logic       locked,
  output logic [2:0] digit_count
);
  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, GRANTED, FAILED
`ifdef PASSWORD_LOCKOUT_EN
    , LOCKED
`endif
  } state_e;
  localparam logic [2:0] MAXF = 3'(MAX_FAIL);
  if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
    $error("MAX_FAIL must be in 1..7");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("LOCK_CYCLES must be at least 1");
  end
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic       mm_q, mm_d, fail_q, fail_d;
  logic [15:0] pw_sh;
  logic        digit_bad;
  // digit_count is 0 in IDLE, so the same shift selects the expected nibble in IDLE and ENTRY
  assign pw_sh     = PASSWORD << {cnt_q[1:0], 2'b00};
  assign digit_bad = digit_in != pw_sh[15:12];
`ifdef PASSWORD_LOCKOUT_EN
  localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  logic [LW-1:0] lock_q, lock_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    mm_d    = mm_q;
    fail_d  = fail_q;
`ifdef PASSWORD_LOCKOUT_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: if (enter_pulse) begin
        mm_d    = digit_bad;
        cnt_d   = 3'd1;
        fail_d  = 1'b0;
        state_d = ENTRY;
      end
      ENTRY: if (enter_pulse) begin
        mm_d    = mm_q | digit_bad;
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd3 ? CHECK : ENTRY;
      end
      CHECK: begin
        state_d = mm_q ? FAILED : GRANTED;
        fcnt_d  = mm_q ? (fcnt_q == MAXF ? fcnt_q : fcnt_q + 3'd1) : 3'd0;
        fail_d  = mm_q;
        cnt_d   = 3'd0;
        mm_d    = 1'b0;
      end
      GRANTED: state_d = logout_pulse ? IDLE : GRANTED;
`ifdef PASSWORD_LOCKOUT_EN
      FAILED: begin
        state_d = fcnt_q == MAXF ? LOCKED : IDLE;
        lock_d  = LW'(LOCK_CYCLES - 1);
      end
      LOCKED: begin
        state_d = lock_q == '0 ? IDLE : LOCKED;
        fcnt_d  = lock_q == '0 ? 3'd0 : fcnt_q;
        fail_d  = lock_q == '0 ? 1'b0 : fail_q;
        lock_d  = lock_q - LW'(1);
      end
`else
      FAILED: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rts) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      mm_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      mm_q    <= mm_d;
      fail_q  <= fail_d;
    end
  end
`ifdef PASSWORD_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rts) lock_q <= '0;
    else     lock_q <= lock_d;
  end
  assign locked = state_q == LOCKED;
`else
  assign locked = 1'b0;
`endif
  assign access      = state_q == GRANTED;
  assign game_en     = access;
  assign fail        = fail_q;
  assign digit_count = cnt_q;
endmodule

// File: tb/tb_password_controller.sv
// tb_password_controller: directed scenarios for password_controller (PASSWORD 5293, MAX_FAIL 3, LOCK_CYCLES 10).
// Output vector order is {access, game_en, fail, locked, digit_count[2:0]}.
module tb_password_controller;
  logic       clk = 1'b0, rts = 1'b1, enter_pulse = 1'b0, logout_pulse = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       access, game_en, fail, locked;
  logic [2:0] digit_count;
  int         checks = 0, errors = 0;
  logic [6:0] outs;
  assign outs = {access, game_en, fail, locked, digit_count};
  always #5 clk = ~clk;
  password_controller #(.PASSWORD(16'h5293), .MAX_FAIL(3), .LOCK_CYCLES(10)) dut (
    .clk(clk), .rts(rts), .enter_pulse(enter_pulse), .logout_pulse(logout_pulse),
    .digit_in(digit_in), .access(access), .game_en(game_en), .fail(fail),
    .locked(locked), .digit_count(digit_count)
  );
  task automatic press(input logic [3:0] d);
    enter_pulse = 1'b1;
    digit_in = d;
    @(negedge clk);
    enter_pulse = 1'b0;
  endtask
  task automatic code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[4*i +: 4]);
  endtask
  task automatic login();
    code(16'h5293);
    @(negedge clk);
  endtask
  task automatic logout();
    logout_pulse = 1'b1;
    @(negedge clk);
    logout_pulse = 1'b0;
  endtask
  task automatic test_reset();
    rts = 1'b1;
    repeat (2) @(negedge clk);
    rts = 1'b0;
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL reset_state: got %b expected %b", outs, 7'b0000000); end
    @(negedge clk);
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL reset_idle: got %b expected %b", outs, 7'b0000000); end
  endtask
  task automatic test_grant();
    logic [15:0] pw = 16'h5293;
    for (int i = 0; i < 4; i++) begin
      press(pw[15-4*i -: 4]);
      checks++;
      if (outs !== {4'b0000, 3'(i + 1)}) begin errors++; $display("FAIL grant_digit%0d: got %b expected %b", i, outs, {4'b0000, 3'(i + 1)}); end
    end
    @(negedge clk);
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL grant_access: got %b expected %b", outs, 7'b1100000); end
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL grant_hold: got %b expected %b", outs, 7'b1100000); end
  endtask
  task automatic test_logout_with_enter();
    enter_pulse = 1'b1;
    logout_pulse = 1'b1;
    digit_in = 4'd5;
    @(negedge clk);
    enter_pulse = 1'b0;
    logout_pulse = 1'b0;
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL logout_wins: got %b expected %b", outs, 7'b0000000); end
    press(4'd5);
    checks++;
    if (outs !== 7'b0000001) begin errors++; $display("FAIL logout_idle_entry: got %b expected %b", outs, 7'b0000001); end
    press(4'd2); press(4'd9); press(4'd3);
    @(negedge clk);
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL relogin: got %b expected %b", outs, 7'b1100000); end
    logout();
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL plain_logout: got %b expected %b", outs, 7'b0000000); end
  endtask
  task automatic test_wrong();
    code(16'h5294);
    checks++;
    if (outs !== 7'b0000100) begin errors++; $display("FAIL wrong_check: got %b expected %b", outs, 7'b0000100); end
    @(negedge clk);
    checks++;
    if (outs !== 7'b0010000) begin errors++; $display("FAIL wrong_fail: got %b expected %b", outs, 7'b0010000); end
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 7'b0010000) begin errors++; $display("FAIL wrong_fail_held: got %b expected %b", outs, 7'b0010000); end
    press(4'd5);
    checks++;
    if (outs !== 7'b0000001) begin errors++; $display("FAIL wrong_fail_clear: got %b expected %b", outs, 7'b0000001); end
    press(4'd2); press(4'd9); press(4'd3);
    @(negedge clk);
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL wrong_then_grant: got %b expected %b", outs, 7'b1100000); end
    logout();
  endtask
  task automatic test_back_to_back();
    logic [15:0] pw = 16'h5293;
    enter_pulse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit_in = pw[15-4*i -: 4];
      @(negedge clk);
      if (i == 3) enter_pulse = 1'b0;
      checks++;
      if (digit_count !== 3'(i + 1)) begin errors++; $display("FAIL b2b_count%0d: got %0d expected %0d", i, digit_count, i + 1); end
    end
    @(negedge clk);
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL b2b_access: got %b expected %b", outs, 7'b1100000); end
    logout();
  endtask
`ifdef PASSWORD_LOCKOUT_EN
  task automatic test_lockout();
    int n = 0;
    for (int j = 0; j < 2; j++) begin
      code(16'h5294);
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 7'b0010000) begin errors++; $display("FAIL lock_pre%0d: got %b expected %b", j, outs, 7'b0010000); end
    end
    login();
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL lock_grant_clears: got %b expected %b", outs, 7'b1100000); end
    logout();
    for (int j = 0; j < 2; j++) begin
      code(16'h1111);
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 7'b0010000) begin errors++; $display("FAIL lock_after_grant%0d: got %b expected %b", j, outs, 7'b0010000); end
    end
    code(16'h5294);
    @(negedge clk);
    checks++;
    if (outs !== 7'b0010000) begin errors++; $display("FAIL lock_fail_state: got %b expected %b", outs, 7'b0010000); end
    @(negedge clk);
    checks++;
    if (outs !== 7'b0011000) begin errors++; $display("FAIL lock_enter: got %b expected %b", outs, 7'b0011000); end
    while (locked === 1'b1 && n < 30) begin
      n++;
      enter_pulse = 1'b1;
      digit_in = 4'd5;
      @(negedge clk);
      checks++;
      if (digit_count !== 3'd0) begin errors++; $display("FAIL lock_ignores_enter: got %0d expected 0", digit_count); end
    end
    enter_pulse = 1'b0;
    checks++;
    if (n !== 10) begin errors++; $display("FAIL lock_length: got %0d expected 10", n); end
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL lock_exit: got %b expected %b", outs, 7'b0000000); end
    login();
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL lock_then_grant: got %b expected %b", outs, 7'b1100000); end
    logout();
  endtask
`else
  task automatic test_no_lockout();
    for (int j = 0; j < 5; j++) begin
      code(16'h5294);
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 7'b0010000) begin errors++; $display("FAIL nolock_fail%0d: got %b expected %b", j, outs, 7'b0010000); end
    end
    login();
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL nolock_grant: got %b expected %b", outs, 7'b1100000); end
    logout();
  endtask
`endif
  task automatic test_reset_mid();
    press(4'd1);
    press(4'd2);
    checks++;
    if (digit_count !== 3'd2) begin errors++; $display("FAIL rst_mid_count: got %0d expected 2", digit_count); end
    rts = 1'b1;
    @(negedge clk);
    rts = 1'b0;
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL rst_mid_entry: got %b expected %b", outs, 7'b0000000); end
    login();
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL rst_mid_regrant: got %b expected %b", outs, 7'b1100000); end
    rts = 1'b1;
    @(negedge clk);
    rts = 1'b0;
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL rst_granted: got %b expected %b", outs, 7'b0000000); end
`ifdef PASSWORD_LOCKOUT_EN
    for (int j = 0; j < 3; j++) begin
      code(16'h5294);
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rst_lock_pre: got %b expected 1", locked); end
    rts = 1'b1;
    @(negedge clk);
    rts = 1'b0;
    checks++;
    if (outs !== 7'b0000000) begin errors++; $display("FAIL rst_locked: got %b expected %b", outs, 7'b0000000); end
`endif
    login();
    checks++;
    if (outs !== 7'b1100000) begin errors++; $display("FAIL rst_final_grant: got %b expected %b", outs, 7'b1100000); end
    logout();
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_grant();
    test_logout_with_enter();
    test_wrong();
    test_back_to_back();
`ifdef PASSWORD_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
